// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a framed byte stream, writes
// little-endian words to imem, and releases the core once the checksum verifies.
module imem_loader #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    HDR0 = 3'd0,
    HDR1 = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  // Largest legal word count; a 16-bit count can never exceed a depth of 2**16 or more.
  localparam logic [16:0] MAX_WORDS = (ADDR_WIDTH >= 16) ? 17'h1_0000 : (17'd1 << ADDR_WIDTH);

  state_t      state_r, state_nxt;
  logic [7:0]  cnt_lo_r;
  logic [15:0] n_r;
  logic [15:0] word_idx_r;
  logic [1:0]  lane_r;
  logic [23:0] asm_r;
  logic [7:0]  csum_r;
  logic        we_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;

  logic        accept_s;
  logic [15:0] n_s;
  logic        last_word_s;

  assign accept_s    = rx_valid && rx_ready;
  assign n_s         = {rx_data, cnt_lo_r};
  assign last_word_s = (word_idx_r == (n_r - 16'd1));

  assign imem_we    = we_r;
  assign imem_addr  = addr_r;
  assign imem_wdata = wdata_r;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= HDR0;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_nxt = state_r;
    rx_ready  = 1'b0;
    core_hold = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    case (state_r)
      HDR0: begin
        rx_ready = 1'b1;
        if (accept_s) begin
          state_nxt = HDR1;
        end else begin
          state_nxt = HDR0;
        end
      end
      HDR1: begin
        rx_ready = 1'b1;
        if (!accept_s) begin
          state_nxt = HDR1;
        end else if ({1'b0, n_s} > MAX_WORDS) begin
          state_nxt = ERR;
        end else if (n_s == 16'd0) begin
          state_nxt = CSUM;
        end else begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        rx_ready = 1'b1;
        if (accept_s && (lane_r == 2'd3) && last_word_s) begin
          state_nxt = CSUM;
        end else begin
          state_nxt = DATA;
        end
      end
      CSUM: begin
        rx_ready = 1'b1;
        if (!accept_s) begin
          state_nxt = CSUM;
        end else if (rx_data == csum_r) begin
          state_nxt = DONE;
        end else begin
          state_nxt = ERR;
        end
      end
      DONE: begin
        core_hold = 1'b0;
        done      = 1'b1;
      end
      ERR: begin
        error = 1'b1;
      end
      default: begin
        state_nxt = ERR;
      end
    endcase
  end

  // Byte assembly, running checksum and imem write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_lo_r   <= 8'h00;
      n_r        <= 16'h0000;
      word_idx_r <= 16'h0000;
      lane_r     <= 2'd0;
      asm_r      <= 24'h00_0000;
      csum_r     <= 8'h00;
      we_r       <= 1'b0;
      addr_r     <= BASE_ADDR;
      wdata_r    <= 32'h0000_0000;
    end else begin
      we_r <= 1'b0;
      if (accept_s) begin
        case (state_r)
          HDR0: begin
            cnt_lo_r <= rx_data;
            csum_r   <= csum_r ^ rx_data;
          end
          HDR1: begin
            n_r    <= n_s;
            csum_r <= csum_r ^ rx_data;
          end
          DATA: begin
            csum_r <= csum_r ^ rx_data;
            lane_r <= lane_r + 2'd1;
            case (lane_r)
              2'd0: asm_r[7:0]   <= rx_data;
              2'd1: asm_r[15:8]  <= rx_data;
              2'd2: asm_r[23:16] <= rx_data;
              default: begin
                // Lane 3 completes the word; the strobe follows on the next cycle.
                wdata_r    <= {rx_data, asm_r};
                we_r       <= 1'b1;
                addr_r     <= BASE_ADDR + {14'd0, word_idx_r, 2'b00};
                word_idx_r <= word_idx_r + 16'd1;
              end
            endcase
          end
          default: begin
            csum_r <= csum_r;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time program loader and the write-side counterpart of the core's read-only instruction memory port. Accepts a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and issues one-cycle write strobes to the imem write port. Holds the core in reset until a frame is fully received and its checksum verifies, then releases it.

Parameters:
ADDR_WIDTH, 10, imem depth in words = 2**ADDR_WIDTH; maximum accepted word count.
BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be 4-byte aligned.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
rx_valid  input  1  byte-stream source has a byte.
rx_data  input  8  byte value.
rx_ready  output  1  loader can accept a byte.
imem_we  output  1  imem write strobe, one cycle per word.
imem_addr  output  32  byte address of the word being written.
imem_wdata  output  32  word being written.
core_hold  output  1  1 = core (pc/REG/dmem) held in reset.
done  output  1  frame loaded and checksum verified; sticky.
error  output  1  frame rejected; sticky.

Behaviour:
- A byte is accepted on a rising clk edge where rx_valid && rx_ready. No other edge consumes data. rx_data is sampled only on acceptance.
- Frame format: CNT_LO, CNT_HI (16-bit word count N, little-endian), then 4*N payload bytes (each word LSB first), then 1 checksum byte. The checksum equals the XOR of every preceding byte in the frame, header included.
- FSM states: HDR0, HDR1, DATA, CSUM, DONE, ERR. The reset state is HDR0.
- HDR0: on acceptance, store CNT_LO and go to HDR1.
- HDR1: on acceptance, form N.
  - If N > 2**ADDR_WIDTH, go to ERR.
  - If N == 0, go to CSUM.
  - Otherwise go to DATA.
- DATA: a 2-bit byte lane counter places each accepted byte at bits [8*lane+7:8*lane] of the assembly register.
  - On acceptance of lane 3, the complete word is registered into imem_wdata.
  - imem_we is high for exactly the next cycle, with imem_addr = BASE_ADDR + 4*word_index.
  - word_index then increments.
  - After word N-1 is accepted, go to CSUM.
- CSUM: on acceptance, compare the received byte with the running XOR. Match goes to DONE; mismatch goes to ERR.
- DONE: rx_ready=0, core_hold=0, done=1. Terminal until reset.
- ERR: rx_ready=0, core_hold=1, error=1. Terminal until reset. Words already written are not rolled back.
- rx_ready is 1 in HDR0, HDR1, DATA and CSUM, combinationally from state. There is no extra bubble after the write strobe, so full throughput is 1 byte/clk.
- imem_we never asserts outside DATA-originated word completions. A zero-length frame produces no writes.
- The running XOR, lane counter and word_index are cleared only by reset.
- Reset values: state=HDR0, rx_ready=1 once reset deasserts, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, core_hold=1, done=0, error=0.
- Reset mid-frame: all state clears immediately (asynchronous). Any pending imem_we is dropped. The next accepted byte is treated as CNT_LO.
- done and error are never both 1. core_hold = ~done at all times.

Test Plan:
- Nominal: feed 02 00 93 00 50 00 13 01 A0 00 73 back-to-back. Expect:
  - imem_we pulses at addr 0x0 with 0x00500093, then at 0x4 with 0x00A00113.
  - done=1 and core_hold=0 one cycle after 0x73 is accepted.
- Bad checksum: same stream with last byte 0x74. Expect both writes, then error=1, done=0, core_hold=1, rx_ready=0.
- Empty frame: 00 00 00 → done=1, zero imem_we pulses. The same with checksum 0x01 → error=1.
- Oversize: ADDR_WIDTH=10, header 01 04 (N=1025) → error=1 after the second byte, no imem_we, rx_ready=0.
- Backpressure/gaps: nominal stream with rx_valid toggled randomly (about 50%). Expect identical writes and addresses, exactly 2 strobes, and no byte duplicated or lost.
- Reset mid-frame: assert rst low after 5 payload bytes of the nominal frame, release it, then send the full nominal frame. Expect outputs at reset values during reset, then the nominal result with writes starting again at 0x0.
